mdu_issue_ctrl: RTL and testbench

Execute-stage controller that sequences the iterative 32-bit multiplier for RV32M MUL/MULH/MULHSU/MULHU instructions. It accepts one M-op at a time from the ID/EX register, launches the multiplier with a one-cycle start pulse, and stalls the pipeline while the op is in flight. It returns the result with a valid/ready handshake toward EX/MEM and safely drains in-flight work on a pipeline flush.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_result_cache.sv | 49 ++++
 rtl/mdu_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the RV32M multiply issue controller.
// MDU_RESULT_CACHE_EN enables the one-entry result cache.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } mdu_state_e;

    localparam int unsigned MDU_TIMEOUT_DEFAULT = 40;

endpackage

// File: rtl/mdu_result_cache.sv
// One-entry {opcode, op1, op2, result} store with exact-match lookup.
// Only instantiated when MDU_RESULT_CACHE_EN is defined.
module mdu_result_cache
    import mdu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [1:0]  wr_opcode_i,
    input  logic [31:0] wr_op1_i,
    input  logic [31:0] wr_op2_i,
    input  logic [31:0] wr_result_i,
    input  logic [1:0]  lk_opcode_i,
    input  logic [31:0] lk_op1_i,
    input  logic [31:0] lk_op2_i,
    output logic        hit_o,
    output logic [31:0] data_o
);

    logic        valid_q;
    mul_op_e     opc_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [31:0] res_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            opc_q   <= OP_MUL;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
        end else if (we_i) begin
            valid_q <= 1'b1;
            opc_q   <= mul_op_e'(wr_opcode_i);
            op1_q   <= wr_op1_i;
            op2_q   <= wr_op2_i;
            res_q   <= wr_result_i;
        end
    end

    assign hit_o = valid_q
                 && (opc_q == mul_op_e'(lk_opcode_i))
                 && (op1_q == lk_op1_i)
                 && (op2_q == lk_op2_i);

    assign data_o = res_q;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// EX-stage sequencer for the iterative RV32M multiplier.
// Optional result cache: define MDU_RESULT_CACHE_EN.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MDU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_opcode,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic        flush,
    input  logic        wb_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        busy,
    output logic        mul_start,
    output logic [1:0]  mul_opcode,
    output logic [31:0] mul_op1,
    output logic [31:0] mul_op2,
    input  logic        mul_done,
    input  logic [31:0] mul_result
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    mdu_state_e  state_q, state_d;
    mul_op_e     opc_q, opc_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        hit;
    logic        tmo;
    logic [31:0] cache_data;

`ifdef MDU_RESULT_CACHE_EN
    logic cache_we;

    // Timed-out and flushed ops never reach the cache.
    assign cache_we = (state_q == ST_WAIT) & mul_done & ~flush;

    mdu_result_cache u_cache (
        .clk_i       (clk),
        .rst_i       (rst),
        .we_i        (cache_we),
        .wr_opcode_i (opc_q),
        .wr_op1_i    (op1_q),
        .wr_op2_i    (op2_q),
        .wr_result_i (mul_result),
        .lk_opcode_i (req_opcode),
        .lk_op1_i    (req_op1),
        .lk_op2_i    (req_op2),
        .hit_o       (hit),
        .data_o      (cache_data)
    );
`else
    assign hit        = 1'b0;
    assign cache_data = '0;
`endif

    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        rd_d      = rd_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        data_d    = data_q;
        err_d     = err_q;
        cnt_d     = cnt_q + CW'(1);
        stall     = 1'b0;
        mul_start = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                stall = req_valid & ~flush & ~hit;
                cnt_d = '0;
                if (req_valid && !flush) begin
                    opc_d = mul_op_e'(req_opcode);
                    rd_d  = req_rd;
                    op1_d = req_op1;
                    op2_d = req_op2;
                    if (hit) begin
                        data_d  = cache_data;
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                stall     = 1'b1;
                mul_start = 1'b1;
                cnt_d     = '0;
                state_d   = flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                stall = 1'b1;
                // Flush beats a same-cycle done; that result is dropped.
                if (flush) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else if (mul_done) begin
                    data_d  = mul_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmo) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                stall = ~wb_ready;
                if (flush || wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                stall = req_valid;
                if (mul_done || tmo) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opc_q   <= OP_MUL;
            rd_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            rd_q    <= rd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign resp_rd    = rd_q;
    assign resp_data  = data_q;
    assign resp_err   = err_q;
    assign mul_opcode = opc_q;
    assign mul_op1    = op1_q;
    assign mul_op2    = op2_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed + randomized bench for mdu_issue_ctrl with a latency-driven
// multiplier model and a one-entry cache reference.
module tb_mdu_issue_ctrl;

    localparam int TMO = 40;
`ifdef MDU_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_opcode = '0;
    logic [4:0]  req_rd = '0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic        flush = 1'b0;
    logic        wb_ready = 1'b0;
    logic        stall;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;
    logic        mul_start;
    logic [1:0]  mul_opcode;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic        mul_done = 1'b0;
    logic [31:0] mul_result = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_opcode (req_opcode),
        .req_rd     (req_rd),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .flush      (flush),
        .wb_ready   (wb_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_opcode (mul_opcode),
        .mul_op1    (mul_op1),
        .mul_op2    (mul_op2),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    function automatic logic [31:0] mref(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb, ub_s;
        logic [63:0] p;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ub_s = {32'b0, b};
        case (op)
            2'b00: p = {32'b0, a} * {32'b0, b};
            2'b01: p = sa * sb;
            2'b10: p = sa * ub_s;
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier model: done pulse `lat` cycles after the start cycle.
    bit     mul_en = 1'b1;
    int     lat = 34;
    bit     pend = 1'b0;
    longint cyc = 0;
    longint due = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            pend = 1'b0;
            mul_done <= 1'b0;
        end else begin
            if (mul_start && mul_en) begin
                pend = 1'b1;
                due  = cyc - 1 + lat;
                mul_result <= mref(mul_opcode, mul_op1, mul_op2);
            end
            mul_done <= pend && (cyc == due);
            if (pend && cyc == due) pend = 1'b0;
        end
    end

    // Reference cache contents
    bit          cvalid = 1'b0;
    logic [1:0]  c_opc;
    logic [31:0] c_a, c_b;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(string tag, logic [1:0] opc, logic [4:0] rd,
                          logic [31:0] a, logic [31:0] b,
                          int l, bit to, int wbd);
        bit          hit;
        int          starts, first_start, rcyc, nostall;
        logic [31:0] ed;
        hit = CACHE && cvalid && c_opc == opc && c_a == a && c_b == b;
        ed  = to ? 32'h0 : mref(opc, a, b);
        lat = l;
        mul_en = !to;
        req_valid = 1'b1;
        req_opcode = opc;
        req_rd = rd;
        req_op1 = a;
        req_op2 = b;
        wb_ready = 1'b0;
        settle();
        chk({tag, "_accept_stall"}, stall, !hit);
        tick();
        req_valid = 1'b0;
        starts = 0;
        first_start = -1;
        rcyc = -1;
        nostall = 0;
        for (int c = 1; c <= 100 && rcyc < 0; c++) begin
            settle();
            if (mul_start) begin
                starts++;
                if (first_start < 0) first_start = c;
            end
            if (resp_valid) rcyc = c;
            else begin
                if (!stall) nostall++;
                tick();
            end
        end
        chk({tag, "_resp_seen"}, rcyc > 0, 1);
        if (hit) begin
            chk({tag, "_hit_cycle"}, rcyc, 1);
            chk({tag, "_hit_starts"}, starts, 0);
        end else begin
            chk({tag, "_starts"}, starts, 1);
            chk({tag, "_start_cycle"}, first_start, 1);
            chk({tag, "_wait_stall"}, nostall, 0);
            if (to)
                chk({tag, "_tmo_window"}, rcyc >= TMO + 2 && rcyc <= TMO + 3, 1);
            else
                chk({tag, "_resp_cycle"}, rcyc, l + 2);
        end
        chk({tag, "_data"}, resp_data, ed);
        chk({tag, "_rd"}, resp_rd, rd);
        chk({tag, "_err"}, resp_err, to);
        for (int k = 0; k <= wbd; k++) begin
            if (k < wbd) begin
                wb_ready = 1'b0;
                settle();
                chk({tag, "_hold_valid"}, resp_valid, 1);
                chk({tag, "_hold_stall"}, stall, 1);
                chk({tag, "_hold_resp"}, {resp_err, resp_rd, resp_data}, {to, rd, ed});
            end else begin
                wb_ready = 1'b1;
                settle();
                chk({tag, "_hs_stall"}, stall, 0);
                chk({tag, "_hs_valid"}, resp_valid, 1);
            end
            tick();
        end
        wb_ready = 1'b0;
        settle();
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_valid"}, resp_valid, 0);
        if (!to) begin
            cvalid = 1'b1;
            c_opc = opc;
            c_a = a;
            c_b = b;
        end
        mul_en = 1'b1;
    endtask

    initial begin
        int nostall, rv, rcyc;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [4:0]  rr;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        tick();
        settle();
        chk("rst_flags", {stall, resp_valid, resp_err, busy, mul_start}, 5'b0);
        chk("rst_resp", {resp_rd, resp_data}, 37'b0);
        chk("rst_mul_ops", {mul_opcode, mul_op1}, 34'b0);
        chk("rst_mul_op2", mul_op2, 32'b0);
        rst = 1'b0;
        tick();

        run_op("mul76", 2'b00, 5'd5, 32'd7, 32'd6, 34, 1'b0, 0);
        run_op("mul76b", 2'b00, 5'd5, 32'd7, 32'd6, 34, 1'b0, 0);
        run_op("mul75", 2'b00, 5'd5, 32'd7, 32'd5, 34, 1'b0, 0);
        run_op("mulhu", 2'b11, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0, 3);
        chk("mulhu_const", mref(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

        // Flush during WAIT, then a request waits out the drain
        lat = 30;
        req_valid = 1'b1;
        req_opcode = 2'b00;
        req_rd = 5'd3;
        req_op1 = 32'd11;
        req_op2 = 32'd9;
        settle();
        chk("fl_accept_stall", stall, 1);
        tick();
        req_valid = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        flush = 1'b1;
        settle();
        chk("fl_flush_stall", stall, 1);
        tick();
        flush = 1'b0;
        settle();
        chk("fl_drain_stall", stall, 0);
        chk("fl_drain_valid", resp_valid, 0);
        chk("fl_drain_busy", busy, 1);
        tick();
        req_valid = 1'b1;
        req_opcode = 2'b00;
        req_rd = 5'd7;
        req_op1 = 32'd3;
        req_op2 = 32'd4;
        nostall = 0;
        rv = 0;
        for (int c = 12; c <= 32; c++) begin
            settle();
            if (!stall) nostall++;
            if (resp_valid || mul_start) rv++;
            tick();
        end
        chk("fl_hold_stall", nostall, 0);
        chk("fl_no_activity", rv, 0);
        req_valid = 1'b0;
        lat = 5;
        settle();
        chk("fl_relaunch", mul_start, 1);
        tick();
        rcyc = -1;
        for (int c = 1; c <= 20 && rcyc < 0; c++) begin
            settle();
            if (resp_valid) rcyc = c;
            else tick();
        end
        chk("fl_resp_cycle", rcyc, 6);
        chk("fl_resp", {resp_err, resp_rd, resp_data}, {1'b0, 5'd7, 32'd12});
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        cvalid = 1'b1;
        c_opc = 2'b00;
        c_a = 32'd3;
        c_b = 32'd4;

        run_op("tmo", 2'b01, 5'd12, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b1, 1);

        ro = '0;
        ra = '0;
        rb = '0;
        rr = '0;
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            rr = 5'($urandom_range(1, 31));
            run_op("rnd", ro, rr, ra, rb, $urandom_range(1, 20), 1'b0,
                   $urandom_range(0, 3));
        end
        run_op("rnd_rep", ro, rr, ra, rb, 8, 1'b0, 0);

        // Reset in WAIT
        lat = 30;
        req_valid = 1'b1;
        req_opcode = 2'b11;
        req_rd = 5'd4;
        req_op1 = 32'd1;
        req_op2 = 32'd2;
        settle();
        tick();
        req_valid = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        settle();
        chk("rs_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        cvalid = 1'b0;
        chk("rs_flags", {stall, resp_valid, resp_err, busy, mul_start}, 5'b0);
        chk("rs_resp", {resp_rd, resp_data}, 37'b0);
        chk("rs_mul_ops", {mul_opcode, mul_op1}, 34'b0);
        chk("rs_mul_op2", mul_op2, 32'b0);
        tick();
        run_op("rs_mul75", 2'b00, 5'd5, 32'd7, 32'd5, 10, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
